fft_bfly_addr_gen: RTL and testbench

//  Address sequencer for the in-place radix-2 DIT FFT core. Walks every

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_bfly_addr_gen_if.sv | 30 +++
 rtl/fft_bfly_addr_calc.sv | 32 +++
 rtl/fft_bfly_addr_gen.sv | 90 +++++++++
 tb/tb_fft_bfly_addr_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT core.
package fft_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned num_stages(int unsigned n_points);
        return $clog2(n_points);
    endfunction

    function automatic int unsigned stage_width(int unsigned n_points);
        return $clog2($clog2(n_points));
    endfunction

    // Reverses the low 'width' bits of x; used by the frame loader to scatter inputs.
    function automatic logic [31:0] bitrev(logic [31:0] x, int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = x[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bfly_addr_gen_if.sv
// Sequencer-to-datapath bundle: framing, backpressure and per-butterfly addresses.
interface fft_bfly_addr_gen_if #(
    parameter int unsigned N_POINTS = 8
);
    localparam int unsigned L  = $clog2(N_POINTS);
    localparam int unsigned SW = $clog2(L);

    logic          start;
    logic          stall;
    logic          busy;
    logic          addr_vld;
    logic [SW-1:0] stage;
    logic [L-2:0]  bfly;
    logic [L-1:0]  addr_a;
    logic [L-1:0]  addr_b;
    logic [L-2:0]  tw_idx;
    logic          last_bfly;
    logic          done;

    modport master (
        input  start, stall,
        output busy, addr_vld, stage, bfly, addr_a, addr_b, tw_idx, last_bfly, done
    );

    modport slave (
        output start, stall,
        input  busy, addr_vld, stage, bfly, addr_a, addr_b, tw_idx, last_bfly, done
    );

endinterface

// File: rtl/fft_bfly_addr_calc.sv
// Combinational (stage, butterfly) -> (addr_a, addr_b, twiddle index) map.
module fft_bfly_addr_calc #(
    parameter int unsigned N_POINTS = 8,
    localparam int unsigned L  = $clog2(N_POINTS),
    localparam int unsigned SW = $clog2(L)
) (
    input  logic [SW-1:0] stage_i,
    input  logic [L-2:0]  bfly_i,
    output logic [L-1:0]  addr_a_o,
    output logic [L-1:0]  addr_b_o,
    output logic [L-2:0]  tw_idx_o
);

    logic [L-1:0] b_ext;
    logic [L-1:0] span;
    logic [L-1:0] pos;
    logic [L-1:0] grp;
    logic [L-1:0] tw_full;

    always_comb begin
        b_ext    = {1'b0, bfly_i};
        span     = L'(1) << stage_i;
        pos      = b_ext & (span - L'(1));
        grp      = b_ext >> stage_i;
        // Groups are 2^(s+1) apart; the butterfly pair is 2^s apart within a group.
        addr_a_o = (grp << (stage_i + 1)) | pos;
        addr_b_o = addr_a_o + span;
        tw_full  = pos << (L - 1 - stage_i);
        tw_idx_o = tw_full[L-2:0];
    end

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// Butterfly address sequencer: walks all stages/butterflies of one in-place FFT frame.
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    fft_bfly_addr_gen_if.master bus_io
);

    localparam int unsigned L  = num_stages(N_POINTS);
    localparam int unsigned SW = stage_width(N_POINTS);
    localparam logic [L-2:0]  BflyMax  = (L-1)'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0] StageMax = SW'(L - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [L-2:0]  bfly_q, bfly_d;
    logic          vld;
    logic [L-1:0]  addr_a_raw;
    logic [L-1:0]  addr_b_raw;
    logic [L-2:0]  tw_idx_raw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StRun;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            StRun: begin
                if (!bus_io.stall) begin
                    if (bfly_q != BflyMax) begin
                        bfly_d = bfly_q + 1'b1;
                    end else if (stage_q != StageMax) begin
                        bfly_d  = '0;
                        stage_d = stage_q + 1'b1;
                    end else begin
                        // Counters are parked at zero so IDLE always reports s=0, b=0.
                        state_d = StDone;
                        bfly_d  = '0;
                        stage_d = '0;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    fft_bfly_addr_calc #(
        .N_POINTS(N_POINTS)
    ) u_calc (
        .stage_i (stage_q),
        .bfly_i  (bfly_q),
        .addr_a_o(addr_a_raw),
        .addr_b_o(addr_b_raw),
        .tw_idx_o(tw_idx_raw)
    );

    assign vld              = (state_q == StRun);
    assign bus_io.busy      = vld;
    assign bus_io.addr_vld  = vld;
    assign bus_io.done      = (state_q == StDone);
    assign bus_io.stage     = stage_q;
    assign bus_io.bfly      = bfly_q;
    assign bus_io.addr_a    = vld ? addr_a_raw : '0;
    assign bus_io.addr_b    = vld ? addr_b_raw : '0;
    assign bus_io.tw_idx    = vld ? tw_idx_raw : '0;
    assign bus_io.last_bfly = vld && (bfly_q == BflyMax);

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Self-checking bench for fft_bfly_addr_gen at N_POINTS=8 with a per-cycle scoreboard.
module tb_fft_bfly_addr_gen;

    localparam int unsigned NPts = 8;

    typedef struct {
        int stage;
        int bfly;
        int a;
        int b;
        int tw;
    } vec_t;

    typedef enum int {MIdle, MRun, MDone} mstate_e;

    logic clk;
    logic rst;

    fft_bfly_addr_gen_if #(.N_POINTS(NPts)) bus ();

    fft_bfly_addr_gen #(
        .N_POINTS(NPts)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t    tbl[12];
    vec_t    q[$];
    mstate_e m_state;
    int      checks;
    int      failures;
    int      done_cnt;
    int      vld_cnt;
    int      last_cnt;
    bit      mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            step();
        end
        chk("done_within_budget", 32'(done_cnt >= target), 1);
    endtask

    // Monitor + reference model, evaluated on the falling edge when inputs are stable.
    initial begin
        m_state  = MIdle;
        done_cnt = 0;
        vld_cnt  = 0;
        last_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("busy", 32'(bus.busy), 32'(m_state == MRun));
                chk("addr_vld", 32'(bus.addr_vld), 32'(m_state == MRun));
                chk("done", 32'(bus.done), 32'(m_state == MDone));
                if (m_state == MRun && q.size() > 0) begin
                    chk("stage", 32'(bus.stage), q[0].stage);
                    chk("bfly", 32'(bus.bfly), q[0].bfly);
                    chk("addr_a", 32'(bus.addr_a), q[0].a);
                    chk("addr_b", 32'(bus.addr_b), q[0].b);
                    chk("tw_idx", 32'(bus.tw_idx), q[0].tw);
                    chk("last_bfly", 32'(bus.last_bfly), 32'(q[0].bfly == 3));
                end else begin
                    chk("addr_a_idle", 32'(bus.addr_a), 0);
                    chk("addr_b_idle", 32'(bus.addr_b), 0);
                    chk("last_bfly_idle", 32'(bus.last_bfly), 0);
                end
                if (bus.done === 1'b1) done_cnt++;
                if (bus.addr_vld === 1'b1) vld_cnt++;
                if (bus.last_bfly === 1'b1) last_cnt++;
                case (m_state)
                    MIdle: begin
                        if (!rst && bus.start) begin
                            foreach (tbl[i]) q.push_back(tbl[i]);
                            m_state = MRun;
                        end
                    end
                    MRun: begin
                        if (rst) begin
                            q.delete();
                            m_state = MIdle;
                        end else if (!bus.stall) begin
                            void'(q.pop_front());
                            if (q.size() == 0) m_state = MDone;
                        end
                    end
                    default: m_state = MIdle;
                endcase
            end
        end
    end

    initial begin
        int d0, v0, l0;
        tbl[0]  = '{0, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 2, 3, 0};
        tbl[2]  = '{0, 2, 4, 5, 0};
        tbl[3]  = '{0, 3, 6, 7, 0};
        tbl[4]  = '{1, 0, 0, 2, 0};
        tbl[5]  = '{1, 1, 1, 3, 2};
        tbl[6]  = '{1, 2, 4, 6, 0};
        tbl[7]  = '{1, 3, 5, 7, 2};
        tbl[8]  = '{2, 0, 0, 4, 0};
        tbl[9]  = '{2, 1, 1, 5, 1};
        tbl[10] = '{2, 2, 2, 6, 2};
        tbl[11] = '{2, 3, 3, 7, 3};
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (2) step();
        rst    = 1'b0;
        mon_en = 1'b1;
        step();
        chk("reset_stage", 32'(bus.stage), 0);
        chk("reset_bfly", 32'(bus.bfly), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);

        // Plain frame.
        d0 = done_cnt; v0 = vld_cnt; l0 = last_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        wait_done(d0 + 1, 40);
        step();
        chk("t1_vld_cycles", 32'(vld_cnt - v0), 12);
        chk("t1_last_pulses", 32'(last_cnt - l0), 3);
        chk("t1_idle_after", 32'(bus.busy), 0);

        // Three stalled edges on s1,b1.
        d0 = done_cnt; v0 = vld_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        repeat (5) step();
        chk("t2_hold_a", 32'(bus.addr_a), 1);
        bus.stall = 1'b1;
        repeat (3) step();
        bus.stall = 1'b0;
        chk("t2_hold_tw", 32'(bus.tw_idx), 2);
        wait_done(d0 + 1, 40);
        chk("t2_vld_cycles", 32'(vld_cnt - v0), 15);

        // start while running is ignored.
        step();
        d0 = done_cnt; v0 = vld_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        repeat (2) step();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        wait_done(d0 + 1, 40);
        repeat (6) step();
        chk("t3_done_once", 32'(done_cnt - d0), 1);
        chk("t3_vld_cycles", 32'(vld_cnt - v0), 12);

        // Reset mid-frame at s2,b1.
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        repeat (9) step();
        chk("t4_pre_rst_bfly", 32'(bus.bfly), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_vld", 32'(bus.addr_vld), 0);
        chk("t4_stage", 32'(bus.stage), 0);
        chk("t4_bfly", 32'(bus.bfly), 0);
        chk("t4_done", 32'(bus.done), 0);
        repeat (4) step();
        chk("t4_no_done", 32'(done_cnt - d0), 0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("t4_restart_a", 32'(bus.addr_a), 0);
        chk("t4_restart_b", 32'(bus.addr_b), 1);
        wait_done(d0 + 1, 40);

        // start held high: back-to-back frames, gap enforced by the per-cycle model.
        step();
        d0 = done_cnt; v0 = vld_cnt; l0 = last_cnt;
        bus.start = 1'b1;
        wait_done(d0 + 3, 100);
        bus.start = 1'b0;
        repeat (3) step();
        chk("t5_frames", 32'(done_cnt - d0), 3);
        chk("t5_vld_cycles", 32'(vld_cnt - v0), 36);
        chk("t5_last_pulses", 32'(last_cnt - l0), 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
